// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
//   Boot-time sequencer for the instruction memory. A loader streams N words
//   over a valid/ready handshake. Each word is written from word 0 upward and
//   added into a running checksum. The image is then read back to confirm the
//   checksum, and the CPU is released. Once the CPU runs, it owns the read port.
// Ports
//   clk, rst_n            clock, async active-low reset
//   start, num_words      begin-load pulse and image length (sampled on start)
//   ld_valid/ld_ready/ld_data   loader word stream
//   mem_we/mem_waddr/mem_wdata  memory write port (byte addresses)
//   mem_raddr/mem_rdata   memory read port (rdata combinational from raddr)
//   cpu_pc/cpu_instr/cpu_run    CPU fetch interface and enable
//   done, err, checksum   verify-pass pulse, sticky error, sum of loaded words
module imem_load_ctrl #(
  parameter int                 WIDTH = 32,
  parameter int                 DEPTH = 1024,
  parameter logic [WIDTH-1:0]   NOP   = 32'h00000013,
  localparam int                AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW:0]      num_words,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] cpu_pc,
  output logic [WIDTH-1:0] cpu_instr,
  output logic             cpu_run,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERROR} state_e;

  state_e           state_q, state_d;
  logic [AW:0]      n_q, n_d;
  logic [AW:0]      wcnt_q, wcnt_d;
  logic [AW:0]      rcnt_q, rcnt_d;
  logic [WIDTH-1:0] checksum_q, checksum_d;
  logic [WIDTH-1:0] vsum_q, vsum_d;
  logic             err_q, err_d;

  logic bad_len;
  assign bad_len = (num_words == '0) || (num_words > (AW+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    checksum_d = checksum_q;
    vsum_d     = vsum_q;
    err_d      = err_q;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_raddr  = cpu_pc;
    cpu_instr  = NOP;
    cpu_run    = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      IDLE, RUN, ERROR: begin
        if (state_q == RUN) begin
          cpu_instr = mem_rdata;
          cpu_run   = 1'b1;
        end
        if (start) begin
          if (bad_len) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d    = LOAD;
            n_d        = num_words;
            wcnt_d     = '0;
            rcnt_d     = '0;
            checksum_d = '0;
            vsum_d     = '0;
            err_d      = 1'b0;
          end
        end
      end
      LOAD: begin
        ld_ready  = 1'b1;
        mem_waddr = WIDTH'({wcnt_q, 2'b00});
        if (ld_valid) begin
          mem_we     = 1'b1;
          mem_wdata  = ld_data;
          checksum_d = checksum_q + ld_data;
          wcnt_d     = wcnt_q + 1'b1;
          if (wcnt_q == n_q - 1'b1) state_d = VERIFY;
        end
      end
      VERIFY: begin
        mem_raddr = WIDTH'({rcnt_q, 2'b00});
        if (rcnt_q != n_q) begin
          vsum_d = vsum_q + mem_rdata;
          rcnt_d = rcnt_q + 1'b1;
        end else if (vsum_q == checksum_q) begin
          // rcnt has run past the last word: this is the compare cycle
          done    = 1'b1;
          state_d = RUN;
        end else begin
          err_d   = 1'b1;
          state_d = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err      = err_q;
  assign checksum = checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      checksum_q <= '0;
      vsum_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      checksum_q <= checksum_d;
      vsum_q     <= vsum_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [AW:0] num_words;
  logic ld_valid;
  logic [31:0] ld_data;
  logic ld_ready, mem_we, cpu_run, done, err;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata, cpu_pc, cpu_instr, checksum;

  imem_load_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .cpu_pc(cpu_pc),
    .cpu_instr(cpu_instr), .cpu_run(cpu_run), .done(done), .err(err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // behavioural instruction memory
  logic [31:0] mem [DEPTH];
  assign mem_rdata = mem[mem_raddr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_waddr[11:2]] <= mem_wdata;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  logic [31:0] wbuf   [DEPTH];
  logic [31:0] shadow [DEPTH];

  int tests = 0;
  int fails = 0;
  int writes = 0;

  // write monitor: every observed write must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      wr_t e;
      writes++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h, required no write", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_waddr !== e.addr || mem_wdata !== e.data) begin
          fails++;
          $display("FAIL write addr=%h data=%h, required addr=%h data=%h",
                   mem_waddr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int n, input int gap);
    start = 1'b1; num_words = (AW+1)'(n); tick(); start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin ld_valid = 1'b0; ld_data = $urandom; tick(); end
      ld_valid = 1'b1; ld_data = wbuf[i];
      exp_q.push_back('{32'(i*4), wbuf[i]});
      shadow[i] = wbuf[i];
      tick();
    end
    ld_valid = 1'b0;
  endtask

  // called one cycle after the final accepting edge; cyc counts cycles since then
  task automatic wait_done(input int budget, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 1;
    while (cyc <= budget) begin
      #1;
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (err === 1'b1) break;
      tick();
      cyc++;
    end
  endtask

  function automatic logic [31:0] sum_buf(input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s += wbuf[i];
    return s;
  endfunction

  task automatic check_idle_outputs(input string tag);
    tests++;
    if (ld_ready !== 0 || mem_we !== 0 || mem_waddr !== 0 || mem_wdata !== 0 ||
        cpu_run !== 0 || done !== 0 || err !== 0 || checksum !== 0 ||
        mem_raddr !== cpu_pc || cpu_instr !== NOP) begin
      fails++;
      $display("FAIL %s rdy=%b we=%b wa=%h wd=%h run=%b done=%b err=%b cs=%h ra=%h ci=%h, required zeros ra=%h ci=%h",
               tag, ld_ready, mem_we, mem_waddr, mem_wdata, cpu_run, done, err, checksum,
               mem_raddr, cpu_instr, cpu_pc, NOP);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; num_words = '0; ld_valid = 0; ld_data = 32'hdeadbeef;
    cpu_pc = 32'h40;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #3;
    check_idle_outputs("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_idle_outputs("after_release");
  endtask

  task automatic test_load_basic();
    int cyc; bit seen;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    start = 1'b1; num_words = 11'd4; #1;
    tests++;
    if (ld_ready !== 1'b0) begin fails++; $display("FAIL ready_before_load got=%b req=0", ld_ready); end
    start = 1'b0;
    do_load(4, 0);
    wait_done(20, cyc, seen);
    tests++;
    if (!seen || cyc != 5) begin
      fails++; $display("FAIL done_latency seen=%0b cyc=%0d, required seen=1 cyc=5", seen, cyc);
    end
    tests++;
    if (checksum !== 32'd10) begin fails++; $display("FAIL checksum got=%h req=%h", checksum, 32'd10); end
    tests++;
    if (exp_q.size() != 0 || writes != 4) begin
      fails++; $display("FAIL write_count got=%0d pending=%0d req=4", writes, exp_q.size());
    end
    tick();
    tests++;
    if (cpu_run !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL run_entry run=%b done=%b err=%b, required 1 0 0", cpu_run, done, err);
    end
  endtask

  task automatic test_run_fetch();
    cpu_pc = 32'd8; #1;
    tests++;
    if (cpu_instr !== 32'd3 || mem_raddr !== 32'd8) begin
      fails++; $display("FAIL fetch_pc8 instr=%h ra=%h, required 3 8", cpu_instr, mem_raddr);
    end
    cpu_pc = 32'd0; #1;
    tests++;
    if (cpu_instr !== 32'd1) begin fails++; $display("FAIL fetch_pc0 instr=%h req=1", cpu_instr); end
    tick();
  endtask

  task automatic test_gaps();
    int cyc; bit seen; int bad = 0; int w0 = writes;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    do_load(4, 2);
    tests++;
    if (writes - w0 != 4) begin fails++; $display("FAIL gap_writes got=%0d req=4", writes - w0); end
    wait_done(20, cyc, seen);
    tests++;
    if (!seen) begin fails++; $display("FAIL gap_done seen=0 req=1"); end
    for (int i = 0; i < 4; i++) if (mem[i] !== 32'(i + 1)) bad++;
    tests++;
    if (bad != 0 || checksum !== 32'd10) begin
      fails++; $display("FAIL gap_image bad=%0d cs=%h, required 0 and %h", bad, checksum, 32'd10);
    end
    tick();
  endtask

  task automatic test_corrupt();
    int cyc; bit seen;
    do_load(4, 0);
    mem[2] = mem[2] ^ 32'h0000_00ff;
    wait_done(20, cyc, seen);
    cpu_pc = 32'd8; #1;
    tests++;
    if (seen || err !== 1'b1 || cpu_run !== 1'b0 || cpu_instr !== NOP) begin
      fails++; $display("FAIL corrupt done_seen=%0b err=%b run=%b instr=%h, required 0 1 0 %h",
                        seen, err, cpu_run, cpu_instr, NOP);
    end
    tick(); tick();
    tests++;
    if (err !== 1'b1 || ld_ready !== 1'b0) begin
      fails++; $display("FAIL error_hold err=%b rdy=%b, required 1 0", err, ld_ready);
    end
  endtask

  task automatic test_bounds();
    int cyc; bit seen; int bad = 0; int w0 = writes;
    int lens[2] = '{0, DEPTH + 1};
    foreach (lens[k]) begin
      start = 1'b1; num_words = (AW+1)'(lens[k]); ld_valid = 1'b1; ld_data = 32'h5; tick();
      start = 1'b0; tick(); ld_valid = 1'b0;
      tests++;
      if (err !== 1'b1 || ld_ready !== 1'b0 || writes != w0) begin
        fails++; $display("FAIL bad_len n=%0d err=%b rdy=%b writes=%0d, required 1 0 %0d",
                          lens[k], err, ld_ready, writes, w0);
      end
    end
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    do_load(DEPTH, 0);
    wait_done(DEPTH + 20, cyc, seen);
    tests++;
    if (!seen || cyc != DEPTH + 1 || err !== 1'b0) begin
      fails++; $display("FAIL full_depth seen=%0b cyc=%0d err=%b, required 1 %0d 0", seen, cyc, err, DEPTH + 1);
    end
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== shadow[i]) bad++;
    tests++;
    if (bad != 0 || checksum !== sum_buf(DEPTH)) begin
      fails++; $display("FAIL shadow_mem bad=%0d cs=%h, required 0 %h", bad, checksum, sum_buf(DEPTH));
    end
    tick();
  endtask

  task automatic test_reset_midload();
    int cyc; bit seen;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h100 + 32'(i);
    start = 1'b1; num_words = 11'd4; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = wbuf[i];
      exp_q.push_back('{32'(i*4), wbuf[i]});
      tick();
    end
    ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset_midload");
    @(negedge clk) rst_n = 1'b1;
    tick();
    tests++;
    if (ld_ready !== 1'b0) begin fails++; $display("FAIL idle_after_reset rdy=%b req=0", ld_ready); end
    do_load(4, 0);
    wait_done(20, cyc, seen);
    tests++;
    if (!seen || cyc != 5 || checksum !== sum_buf(4)) begin
      fails++; $display("FAIL reload seen=%0b cyc=%0d cs=%h, required 1 5 %h", seen, cyc, checksum, sum_buf(4));
    end
    tick();
    tests++;
    if (cpu_run !== 1'b1) begin fails++; $display("FAIL reload_run run=%b req=1", cpu_run); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_run_fetch();
    test_gaps();
    test_corrupt();
    test_bounds();
    test_reset_midload();
    tick();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL missing_writes pending=%0d req=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
